// File: rtl/neighbor_bank_arbiter_pkg.sv
// neighbor_bank_arbiter_pkg: shared bank-state type, default sizes and the bank-select field macro
`ifndef NBA_BANK_SEL
`define NBA_BANK_SEL(a, aw, bw) a[(aw)-1 -: (bw)]
`endif

package neighbor_bank_arbiter_pkg;
    localparam int NUM_PE_DEF = 4;
    localparam int NUM_BANK_DEF = 4;
    typedef enum logic [1:0] {FREE, ISSUE, WAIT} bank_state_e;
endpackage

// File: rtl/neighbor_bank_arbiter_rr_picker.sv
// neighbor_bank_arbiter_rr_picker: first requester at or after ptr, wrapping, as one-hot plus index
module neighbor_bank_arbiter_rr_picker #(
    parameter int N = 4,
    parameter int TAG_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [TAG_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [TAG_W-1:0] idx,
    output logic             any
);
    logic [TAG_W-1:0] c;
    // Scan from the farthest offset down so the nearest requester is written last
    always_comb begin
        idx = '0;
        any = 1'b0;
        c = '0;
        for (int k = N - 1; k >= 0; k--) begin
            c = ptr + TAG_W'(k);
            if (req[c]) begin
                idx = c;
                any = 1'b1;
            end
        end
    end
    assign gnt = any ? N'(1) << idx : '0;
endmodule

// File: rtl/neighbor_bank_arbiter.sv
// neighbor_bank_arbiter: round-robin sharing of neighbor-bank controllers among Edge PEs
module neighbor_bank_arbiter
    import neighbor_bank_arbiter_pkg::*;
#(
    parameter int NUM_PE = NUM_PE_DEF,
    parameter int NUM_BANK = NUM_BANK_DEF,
    parameter int ADDR_W = 16,
    parameter int BANK_W = $clog2(NUM_BANK),
    parameter int TAG_W = $clog2(NUM_PE)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_PE-1:0]                    req_valid,
    input  logic [NUM_PE*ADDR_W-1:0]             req_addr,
    output logic [NUM_PE-1:0]                    req_ready,
    output logic [NUM_BANK-1:0]                  bank_valid,
    output logic [NUM_BANK*(ADDR_W-BANK_W)-1:0]  bank_addr,
    output logic [NUM_BANK*TAG_W-1:0]            bank_pe_tag,
    input  logic [NUM_BANK-1:0]                  bank_busy,
    output logic                                 arb_idle
);
    localparam int LW = ADDR_W - BANK_W;
    logic [ADDR_W-1:0] addr [NUM_PE];
    logic [NUM_PE-1:0] gnt [NUM_BANK];
    logic [NUM_BANK-1:0] free;
    for (genvar i = 0; i < NUM_PE; i++) begin : g_pe
        assign addr[i] = req_addr[i*ADDR_W +: ADDR_W];
    end
    for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
        bank_state_e st;
        logic [TAG_W-1:0] ptr, idx, t_q;
        logic [LW-1:0] a_q;
        logic [NUM_PE-1:0] cand, pick;
        logic any;
        always_comb begin
            cand = '0;
            for (int i = 0; i < NUM_PE; i++)
                cand[i] = req_valid[i] && (`NBA_BANK_SEL(addr[i], ADDR_W, BANK_W) == BANK_W'(b));
        end
        neighbor_bank_arbiter_rr_picker #(.N(NUM_PE), .TAG_W(TAG_W)) u_pick (
            .req(cand),
            .ptr(ptr),
            .gnt(pick),
            .idx(idx),
            .any(any)
        );
        assign free[b] = st == FREE;
        assign gnt[b] = free[b] ? pick : '0;
        // ISSUE ignores busy: the controller only sees the request during that cycle
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                st <= FREE;
                ptr <= '0;
                a_q <= '0;
                t_q <= '0;
            end else begin
                st <= st == FREE ? (any ? ISSUE : FREE) : st == ISSUE ? WAIT : (bank_busy[b] ? WAIT : FREE);
                if (free[b] && any) begin
                    ptr <= idx + TAG_W'(1);
                    a_q <= addr[idx][LW-1:0];
                    t_q <= idx;
                end
            end
        end
        assign bank_valid[b] = st == ISSUE;
        assign bank_addr[b*LW +: LW] = a_q;
        assign bank_pe_tag[b*TAG_W +: TAG_W] = t_q;
    end
    always_comb begin
        req_ready = '0;
        if (!reset)
            for (int b = 0; b < NUM_BANK; b++) req_ready = req_ready | gnt[b];
    end
    assign arb_idle = reset || (&free && !(|req_valid));
endmodule

// File: tb/tb_neighbor_bank_arbiter.sv
// tb_neighbor_bank_arbiter: directed scenarios checked against a cycle-timing model of bank locking
module tb_neighbor_bank_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] req_valid = '0;
    logic [63:0] req_addr = '0;
    logic [3:0] req_ready;
    logic [3:0] bank_valid;
    logic [55:0] bank_addr;
    logic [7:0] bank_pe_tag;
    logic [3:0] bank_busy = '0;
    logic arb_idle;
    int total = 0;
    int bad = 0;
    bit run = 1'b0;

    neighbor_bank_arbiter dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_addr(req_addr),
        .req_ready(req_ready),
        .bank_valid(bank_valid),
        .bank_addr(bank_addr),
        .bank_pe_tag(bank_pe_tag),
        .bank_busy(bank_busy),
        .arb_idle(arb_idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask

    // Model: a bank is locked from its grant; its issue pulse is the cycle after the grant;
    // it unlocks at the end of any cycle at least two after the grant in which busy is low.
    int cyc = 0;
    bit locked [4];
    int gcyc [4];
    int ptr [4];
    logic [13:0] m_addr [4];
    logic [1:0] m_tag [4];

    function automatic int winner(input int b);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (ptr[b] + k) % 4;
            if (req_valid[i] && req_addr[i*16+14 +: 2] == 2'(b)) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_ready();
        logic [3:0] r;
        r = '0;
        if (!reset)
            for (int b = 0; b < 4; b++)
                if (!locked[b] && winner(b) >= 0) r[winner(b)] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 4; b++) begin
                locked[b] <= 1'b0;
                gcyc[b] <= -10;
                ptr[b] <= 0;
                m_addr[b] <= '0;
                m_tag[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                int w;
                w = locked[b] ? -1 : winner(b);
                if (locked[b] && cyc >= gcyc[b] + 2 && !bank_busy[b]) locked[b] <= 1'b0;
                if (w >= 0) begin
                    locked[b] <= 1'b1;
                    gcyc[b] <= cyc;
                    ptr[b] <= (w + 1) % 4;
                    m_addr[b] <= req_addr[w*16 +: 14];
                    m_tag[b] <= 2'(w);
                end
            end
        end
        cyc <= cyc + 1;
    end

    logic [3:0] ev;
    logic [55:0] ea;
    logic [7:0] et;
    bit any_lock;
    always @(negedge clk) begin
        if (run) begin
            any_lock = 1'b0;
            for (int b = 0; b < 4; b++) begin
                ev[b] = (gcyc[b] + 1 == cyc);
                ea[b*14 +: 14] = m_addr[b];
                et[b*2 +: 2] = m_tag[b];
                any_lock = any_lock | locked[b];
            end
            chk("m_ready", req_ready, model_ready());
            chk("m_valid", bank_valid, ev);
            chk("m_addr", bank_addr, ea);
            chk("m_tag", bank_pe_tag, et);
            chk("m_idle", arb_idle, reset || (!any_lock && req_valid == 0));
        end
    end

    task automatic neg();
        @(negedge clk);
    endtask

    // PEs drop their request after the edge that accepted it
    task automatic adv();
        logic [3:0] r;
        r = req_ready;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~r;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            neg();
            adv();
        end
    endtask

    task automatic req(input int pe, input logic [15:0] a);
        req_addr[pe*16 +: 16] = a;
        req_valid[pe] = 1'b1;
    endtask

    int order [3] = '{0, 1, 3};

    initial begin
        run = 1'b1;
        neg();
        chk("rst_ready", req_ready, 4'b0000);
        chk("rst_idle", arb_idle, 1'b1);
        @(posedge clk);
        #1 reset = 1'b0;

        req(2, 16'h4123);
        neg();
        chk("t1_ready", req_ready, 4'b0100);
        adv();
        neg();
        chk("t1_valid", bank_valid, 4'b0010);
        chk("t1_addr", bank_addr[14 +: 14], 14'h0123);
        chk("t1_tag", bank_pe_tag[3:2], 2'd2);
        adv();
        neg();
        chk("t1_wait_idle", arb_idle, 1'b0);
        adv();
        neg();
        chk("t1_free_idle", arb_idle, 1'b1);
        adv();

        req(0, 16'h0001);
        req(1, 16'h0002);
        req(3, 16'h0003);
        for (int g = 0; g < 3; g++) begin
            neg();
            chk("t2_grant", req_ready, 4'b1 << order[g]);
            adv();
            neg();
            chk("t2_issue", bank_valid, 4'b0001);
            adv();
            bank_busy[0] = 1'b1;
            repeat (4) begin
                neg();
                chk("t2_lock", req_ready, 4'b0000);
                adv();
            end
            bank_busy[0] = 1'b0;
            neg();
            chk("t2_fall", req_ready, 4'b0000);
            adv();
        end
        req(0, 16'h0004);
        req(2, 16'h0005);
        neg();
        chk("t2_ptr0", req_ready, 4'b0001);
        adv();
        idle_cycles(2);
        neg();
        chk("t2_next", req_ready, 4'b0100);
        adv();
        idle_cycles(2);

        req(0, 16'h0010);
        req(1, 16'h4020);
        req(2, 16'h8030);
        req(3, 16'hC040);
        neg();
        chk("t3_ready", req_ready, 4'b1111);
        adv();
        neg();
        chk("t3_valid", bank_valid, 4'b1111);
        chk("t3_tag", bank_pe_tag, 8'hE4);
        chk("t3_addr2", bank_addr[28 +: 14], 14'h0030);
        adv();
        idle_cycles(2);

        req(0, 16'hC001);
        neg();
        chk("t4_first", req_ready, 4'b0001);
        adv();
        bank_busy[3] = 1'b1;
        req(1, 16'hC002);
        repeat (10) begin
            neg();
            chk("t4_lock", req_ready, 4'b0000);
            adv();
        end
        bank_busy[3] = 1'b0;
        neg();
        chk("t4_fall", req_ready, 4'b0000);
        adv();
        neg();
        chk("t4_grant", req_ready, 4'b0010);
        adv();
        idle_cycles(2);

        req(1, 16'h8100);
        neg();
        chk("t5_first", req_ready, 4'b0010);
        adv();
        bank_busy[2] = 1'b1;
        req(0, 16'h8200);
        req(2, 16'h8300);
        neg();
        adv();
        neg();
        chk("t5_wait", req_ready, 4'b0000);
        adv();
        reset = 1'b1;
        #1;
        chk("t5_rst_valid", bank_valid, 4'b0000);
        chk("t5_rst_addr", bank_addr, 56'h0);
        chk("t5_rst_tag", bank_pe_tag, 8'h00);
        chk("t5_rst_ready", req_ready, 4'b0000);
        chk("t5_rst_idle", arb_idle, 1'b1);
        neg();
        adv();
        reset = 1'b0;
        bank_busy[2] = 1'b0;
        neg();
        chk("t5_low_first", req_ready, 4'b0001);
        adv();
        idle_cycles(2);
        neg();
        chk("t5_then", req_ready, 4'b0100);
        adv();
        idle_cycles(2);

        req(0, 16'h8011);
        req(3, 16'h8033);
        neg();
        chk("t6_wrap", req_ready, 4'b1000);
        adv();
        idle_cycles(2);
        neg();
        chk("t6_next", req_ready, 4'b0001);
        adv();
        idle_cycles(3);
        neg();
        chk("end_idle", arb_idle, 1'b1);
        run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
